// File: rtl/text_video_gen.sv
// text_video_gen: programmable-timing VGA text renderer with attribute byte,
// 16-entry writable palette, character blink and hardware cursor.
module text_video_gen #(
    parameter int          H_ACTIVE     = 1024,
    parameter int          H_SYNC_START = 1024,
    parameter int          H_SYNC_END   = 1160,
    parameter int          H_TOTAL      = 1344,
    parameter int          V_ACTIVE     = 768,
    parameter int          V_SYNC_START = 768,
    parameter int          V_SYNC_END   = 774,
    parameter int          V_TOTAL      = 806,
    parameter bit          SYNC_ACTIVE  = 1'b0,
    parameter logic [15:0] CHAR_BASE    = 16'h8000,
    parameter logic [15:0] ATTR_BASE    = 16'hA000,
    parameter logic [15:0] FONT_BASE    = 16'hC000,
    parameter int          COLS_LOG2    = 7,
    parameter int          BLINK_LOG2   = 5
) (
    input  logic        pixel_clock,
    input  logic        reset_n,
    output logic [15:0] VAB,
    input  logic [7:0]  VIN,
    output logic [3:0]  R,
    output logic [3:0]  G,
    output logic [3:0]  B,
    output logic        hsync_pulse,
    output logic        vsync_pulse,
    output logic        de,
    output logic        frame_start,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_x,
    input  logic [6:0]  cursor_y,
    input  logic        pal_we,
    input  logic [3:0]  pal_addr,
    input  logic [11:0] pal_data
);

    localparam logic [10:0] L_HA        = 11'(H_ACTIVE);
    localparam logic [10:0] L_HSS       = 11'(H_SYNC_START);
    localparam logic [10:0] L_HSE       = 11'(H_SYNC_END);
    localparam logic [10:0] L_HT_M1     = 11'(H_TOTAL - 1);
    localparam logic [10:0] L_VA        = 11'(V_ACTIVE);
    localparam logic [10:0] L_VSS       = 11'(V_SYNC_START);
    localparam logic [10:0] L_VSE       = 11'(V_SYNC_END);
    localparam logic [10:0] L_VT_M1     = 11'(V_TOTAL - 1);
    localparam logic [7:0]  L_LAST_CELL = 8'(H_TOTAL / 8 - 1);

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic [15:0] r_frame_count;
    logic [7:0]  r_code;
    logic [7:0]  r_attr;
    logic [7:0]  r_pending;
    logic [7:0]  r_shift;
    logic [7:0]  r_disp_attr;
    logic        r_disp_hit;
    logic [11:0] r_pal [16];

    logic        w_h_last;
    logic        w_v_last;
    logic [10:0] w_v_next;
    logic        w_fetch_wrap;
    logic [7:0]  w_fetch_col;
    logic [10:0] w_fetch_v;
    logic [2:0]  w_pixrow;
    logic [15:0] w_cell_off;
    logic        w_fetch_hit;
    logic        w_active;
    logic        w_blink_phase;
    logic [3:0]  w_fg;
    logic [3:0]  w_bg;
    logic [3:0]  w_idx;

    assign w_h_last      = (r_hcount == L_HT_M1);
    assign w_v_last      = (r_vcount == L_VT_M1);
    assign w_v_next      = w_v_last ? 11'd0 : r_vcount + 11'd1;
    // The last cell slot of a line prefetches cell 0 of the following line.
    assign w_fetch_wrap  = (r_hcount[10:3] == L_LAST_CELL);
    assign w_fetch_col   = w_fetch_wrap ? 8'd0 : r_hcount[10:3] + 8'd1;
    assign w_fetch_v     = w_fetch_wrap ? w_v_next : r_vcount;
    assign w_pixrow      = w_fetch_v[2:0];
    assign w_cell_off    = (16'(w_fetch_v[10:3]) << COLS_LOG2) + 16'(w_fetch_col);
    assign w_fetch_hit   = cursor_en && (w_fetch_col == 8'(cursor_x)) &&
                           (w_fetch_v[10:3] == 8'(cursor_y)) && (w_pixrow[2:1] == 2'b11);
    assign w_active      = (r_hcount < L_HA) && (r_vcount < L_VA);
    assign w_blink_phase = r_frame_count[BLINK_LOG2];

    // Colour selection: attribute blink first, then cursor inversion on top.
    always_comb begin
        w_fg = r_disp_attr[3:0];
        w_bg = {1'b0, r_disp_attr[6:4]};
        if (r_disp_attr[7] && !w_blink_phase) begin
            w_fg = w_bg;
        end
        if (r_disp_hit && w_blink_phase) begin
            w_fg = {1'b0, r_disp_attr[6:4]};
            w_bg = (r_disp_attr[7] && !w_blink_phase) ? {1'b0, r_disp_attr[6:4]} : r_disp_attr[3:0];
        end
        w_idx = r_shift[7] ? w_fg : w_bg;
    end

    // Horizontal/vertical counters and the frame counter used for blink.
    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            r_hcount      <= 11'd0;
            r_vcount      <= 11'd0;
            r_frame_count <= 16'd0;
        end else if (w_h_last) begin
            r_hcount <= 11'd0;
            r_vcount <= w_v_next;
            if (w_v_next == L_VSS) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end else begin
            r_hcount <= r_hcount + 11'd1;
        end
    end

    // Cell fetch sequencer: char, attr and font reads across one 8-clock slot.
    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            VAB       <= 16'd0;
            r_code    <= 8'd0;
            r_attr    <= 8'd0;
            r_pending <= 8'd0;
        end else begin
            case (r_hcount[2:0])
                3'd0: VAB <= CHAR_BASE + w_cell_off;
                3'd2: begin
                    r_code <= VIN;
                    VAB    <= ATTR_BASE + w_cell_off;
                end
                3'd4: begin
                    r_attr <= VIN;
                    VAB    <= FONT_BASE + {5'd0, r_code, w_pixrow};
                end
                3'd6: r_pending <= VIN;
                default: ;
            endcase
        end
    end

    // Display registers: load the fetched cell at the slot boundary, else shift.
    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            r_shift     <= 8'd0;
            r_disp_attr <= 8'd0;
            r_disp_hit  <= 1'b0;
        end else if (r_hcount[2:0] == 3'd7) begin
            r_shift     <= r_pending;
            r_disp_attr <= r_attr;
            r_disp_hit  <= w_fetch_hit;
        end else begin
            r_shift <= {r_shift[6:0], 1'b0};
        end
    end

    // Palette storage, reset to a grey ramp; writes are visible one clock later.
    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                r_pal[i] <= {4'(i), 4'(i), 4'(i)};
            end
        end else if (pal_we) begin
            r_pal[pal_addr] <= pal_data;
        end
    end

    // Registered video outputs, one clock behind the counters.
    always_ff @(posedge pixel_clock) begin
        if (!reset_n) begin
            {R, G, B}   <= 12'd0;
            de          <= 1'b0;
            frame_start <= 1'b0;
            hsync_pulse <= ~SYNC_ACTIVE;
            vsync_pulse <= ~SYNC_ACTIVE;
        end else begin
            {R, G, B}   <= w_active ? r_pal[w_idx] : 12'd0;
            de          <= w_active;
            frame_start <= (r_hcount == 11'd0) && (r_vcount == 11'd0);
            hsync_pulse <= (r_hcount >= L_HSS && r_hcount < L_HSE) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_pulse <= (r_vcount >= L_VSS && r_vcount < L_VSE) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

endmodule

// File: tb/tb_text_video_gen.sv
// tb_text_video_gen: directed/randomized bench for text_video_gen with a
// cell-level reference model of the picture and a 2-clock VRAM model.
module tb_text_video_gen;

    localparam int HA  = 32;
    localparam int HSS = 40;
    localparam int HSE = 48;
    localparam int HT  = 64;
    localparam int VA  = 16;
    localparam int VSS = 17;
    localparam int VSE = 19;
    localparam int VT  = 20;
    localparam int CL2 = 2;
    localparam int BL2 = 1;
    localparam int FR  = HT * VT;
    localparam int CB  = 'h8000;
    localparam int AB  = 'hA000;
    localparam int FB  = 'hC000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] vab;
    logic [7:0]  vin;
    logic [3:0]  r_o, g_o, b_o;
    logic        hs, vs, de, fs;
    logic        cursor_en = 1'b0;
    logic [6:0]  cursor_x = 7'd0;
    logic [6:0]  cursor_y = 7'd0;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_addr = 4'd0;
    logic [11:0] pal_data = 12'd0;

    logic [7:0]  mem [65536];
    logic [11:0] mpal [16];
    int          checks = 0;
    int          errors = 0;
    int          tcur = 0;

    text_video_gen #(
        .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
        .SYNC_ACTIVE(1'b0), .COLS_LOG2(CL2), .BLINK_LOG2(BL2)
    ) dut (
        .pixel_clock(clk), .reset_n(reset_n), .VAB(vab), .VIN(vin),
        .R(r_o), .G(g_o), .B(b_o), .hsync_pulse(hs), .vsync_pulse(vs),
        .de(de), .frame_start(fs), .cursor_en(cursor_en), .cursor_x(cursor_x),
        .cursor_y(cursor_y), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data)
    );

    always #5 clk = ~clk;

    // VRAM: data for an address appears on the second edge after it is presented.
    always @(posedge clk) vin <= mem[vab];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed %0h expected %0h", tag, tcur, obs, exp);
        end
    endtask

    task automatic reset_model_pal();
        for (int i = 0; i < 16; i++) mpal[i] = {4'(i), 4'(i), 4'(i)};
    endtask

    // Expected colour of a visible pixel from frame/line/pixel position.
    function automatic logic [11:0] model_rgb(input int f, input int h, input int v);
        int col, row, pr, off, code, attr, font, bitv, phase, fg, bg, tmp;
        if (f == 0 && v == 0 && h < 8) return mpal[0];
        col   = h / 8;
        row   = v / 8;
        pr    = v % 8;
        off   = row * (1 << CL2) + col;
        code  = int'(mem[(CB + off) & 'hFFFF]);
        attr  = int'(mem[(AB + off) & 'hFFFF]);
        font  = int'(mem[(FB + code * 8 + pr) & 'hFFFF]);
        bitv  = (font >> (7 - h % 8)) & 1;
        phase = (f >> BL2) & 1;
        fg    = attr & 15;
        bg    = (attr >> 4) & 7;
        if ((attr & 128) != 0 && phase == 0) fg = bg;
        if (cursor_en && col == int'(cursor_x) && row == int'(cursor_y) && pr >= 6 && phase == 1) begin
            tmp = fg; fg = bg; bg = tmp;
        end
        return mpal[bitv != 0 ? fg : bg];
    endfunction

    // Expected VRAM address while the slot for the next cell is being fetched.
    function automatic logic [15:0] model_vab(input int h, input int v);
        int nc, nv, off, a;
        nc = h / 8 + 1;
        nv = v;
        if (nc == HT / 8) begin
            nc = 0;
            nv = (v + 1) % VT;
        end
        off = (nv / 8) * (1 << CL2) + nc;
        case (h % 8)
            0:       a = CB + off;
            2:       a = AB + off;
            default: a = FB + int'(mem[(CB + off) & 'hFFFF]) * 8 + nv % 8;
        endcase
        return 16'(a & 'hFFFF);
    endfunction

    task automatic check_cycle(input int t);
        int f, rr, h, v;
        logic act;
        logic [7:0] pat;
        tcur = t;
        f  = t / FR;
        rr = t % FR;
        v  = rr / HT;
        h  = rr % HT;
        act = (h < HA) && (v < VA);
        chk("de", 32'(de), 32'(act));
        chk("hsync", 32'(hs), (h >= HSS && h < HSE) ? 0 : 1);
        chk("vsync", 32'(vs), (v >= VSS && v < VSE) ? 0 : 1);
        chk("frame_start", 32'(fs), (h == 0 && v == 0) ? 1 : 0);
        chk("rgb", 32'({r_o, g_o, b_o}), act ? 32'(model_rgb(f, h, v)) : 0);
        if (h % 8 == 0 || h % 8 == 2 || h % 8 == 4) chk("vab", 32'(vab), 32'(model_vab(h, v)));
        if (v == 8 && h == 16) chk("vab_row1_cell3", 32'(vab), 32'h8007);
        if (f == 1 && v == 0 && h < 8) begin
            pat = 8'hA5;
            chk("line0_pattern", 32'({r_o, g_o, b_o}), 32'(pat[7 - h] ? mpal[14] : mpal[1]));
        end
    endtask

    task automatic run_cycles(input int n, input int wr_t);
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
            check_cycle(t);
            if (pal_we) begin
                mpal[pal_addr] = pal_data;
                pal_we = 1'b0;
            end
            if (t == wr_t) begin
                pal_we = 1'b1; pal_addr = 4'd14; pal_data = 12'hF00;
            end else if (t < n - 2 && $urandom_range(0, 63) == 0) begin
                pal_we = 1'b1; pal_addr = 4'($urandom_range(0, 15)); pal_data = 12'($urandom);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rgb"}, 32'({r_o, g_o, b_o}), 0);
        chk({tag, "_de"}, 32'(de), 0);
        chk({tag, "_fs"}, 32'(fs), 0);
        chk({tag, "_hsync"}, 32'(hs), 1);
        chk({tag, "_vsync"}, 32'(vs), 1);
        chk({tag, "_vab"}, 32'(vab), 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h8000] = 8'h41;
        mem[16'hA000] = 8'h1E;
        mem[16'hC208] = 8'hA5;
        mem[16'hA001] = 8'h9E;
        reset_model_pal();
        cursor_en = 1'b1;
        cursor_x  = 7'd0;
        cursor_y  = 7'd0;

        // Reset state.
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Four full frames plus part of a fifth, ending just before line 10, pixel 20.
        run_cycles(4 * FR + 10 * HT + 20, FR + 3 * HT + 10);

        // One-clock reset mid-line.
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        tcur = -1;
        check_reset_outputs("midline_reset");
        reset_model_pal();
        cursor_x = 7'd2;
        cursor_y = 7'd1;
        reset_n  = 1'b1;

        // Timing and blink restart from (0,0) with frame_count cleared.
        run_cycles(3 * FR + 100, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
